// File: rtl/ls_align_unit.sv
// -----------------------------------------------------------------------------
// ls_align_unit
// Load/store alignment unit sitting between the MEM pipeline stage and the
// data cache. Loads are merged and sign/zero-extended, stores are lane-shifted
// with matching byte enables, and accesses that straddle a memory word are
// split into two memory transactions. The pipeline is held via BUSYWAIT.
//
// Parameters:
//   DATA_W : memory word / register width (32 or 64)
//   ADDR_W : byte address width
//
// Ports:
//   CLK, RESET      : clock, asynchronous active-high reset
//   MEM_READ/WRITE  : load/store request, held until BUSYWAIT is low
//   FUNC3           : RISC-V load/store funct3
//   ADDR, DATA2     : byte address and store data
//   DATA_OUT        : registered, refined load result
//   BUSYWAIT        : pipeline stall
//   mem_*           : registered memory-side request, mem_rdata/mem_busywait in
//   MISALIGN        : (only with MISALIGN_TRAP_EN) high during DONE of a trapped
//                     misaligned request
//
// Build option: define MISALIGN_TRAP_EN to trap word-crossing accesses instead
// of splitting them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module ls_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                MEM_READ,
    input  logic                MEM_WRITE,
    input  logic [2:0]          FUNC3,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [DATA_W-1:0]   DATA2,
    output logic [DATA_W-1:0]   DATA_OUT,
    output logic                BUSYWAIT,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_byteen,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_busywait
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                MISALIGN
`endif
);

    localparam int B     = DATA_W / 8;
    localparam int OFF_W = $clog2(B);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next;

    // request captured in IDLE and used for the rest of the operation
    logic                store_r;
    logic [2:0]          func3_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   data2_r;
    logic [DATA_W-1:0]   hold_r;

    // request view: live inputs in IDLE, latched copy afterwards
    logic                req_store_s;
    logic [2:0]          req_func3_s;
    logic [ADDR_W-1:0]   req_addr_s;
    logic [DATA_W-1:0]   req_data2_s;

    logic [OFF_W-1:0]    off_s;
    logic [3:0]          size_s;
    logic [4:0]          sum_s;
    logic                split_s;
    logic                legal_s;
    logic [2*B-1:0]      mask_s;
    logic [2*B-1:0]      lanes_s;
    logic [2*DATA_W-1:0] wide_wdata_s;
    logic [ADDR_W-1:0]   base_addr_s;
    logic [ADDR_W-1:0]   next_addr_s;

    logic                busywait_s;
    logic                mem_read_n;
    logic                mem_write_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_n;
    logic [B-1:0]        mem_byteen_n;

    // Legal funct3 encodings; ld/lwu/sd only exist on the 64-bit variant.
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        logic ok;
        if (store) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                3'b011:                 ok = (DATA_W == 64);
                default:                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                3'b011, 3'b110:                         ok = (DATA_W == 64);
                default:                                ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Shift the {second, first} word pair down to the access offset and extend.
    function automatic logic [DATA_W-1:0] refine(input logic [2*DATA_W-1:0] pair,
                                                 input logic [OFF_W-1:0]    off,
                                                 input logic [2:0]          f3);
        logic [DATA_W-1:0] raw;
        logic [DATA_W-1:0] res;
        int                nbits;
        logic              sgn;
        logic              fill;
        raw = DATA_W'(pair >> {off, 3'b000});
        case (f3)
            3'b000:  begin nbits = 8;      sgn = 1'b1; end
            3'b001:  begin nbits = 16;     sgn = 1'b1; end
            3'b010:  begin nbits = 32;     sgn = 1'b1; end
            3'b100:  begin nbits = 8;      sgn = 1'b0; end
            3'b101:  begin nbits = 16;     sgn = 1'b0; end
            3'b110:  begin nbits = 32;     sgn = 1'b0; end
            default: begin nbits = DATA_W; sgn = 1'b0; end
        endcase
        fill = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            fill = (i == nbits - 1) ? (sgn & raw[i]) : fill;
        end
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = (i < nbits) ? raw[i] : fill;
        end
        return res;
    endfunction

    // Select the request fields the current cycle should work from.
    always_comb begin
        if (state_r == IDLE) begin
            req_store_s = MEM_WRITE;   // store wins when both strobes are high
            req_func3_s = FUNC3;
            req_addr_s  = ADDR;
            req_data2_s = DATA2;
        end else begin
            req_store_s = store_r;
            req_func3_s = func3_r;
            req_addr_s  = addr_r;
            req_data2_s = data2_r;
        end
    end

    // Access geometry: offset, size, word-crossing, lane masks and shifted data.
    always_comb begin
        off_s = req_addr_s[OFF_W-1:0];
        case (req_func3_s[1:0])
            2'b00:   size_s = 4'd1;
            2'b01:   size_s = 4'd2;
            2'b10:   size_s = 4'd4;
            default: size_s = 4'd8;
        endcase
        sum_s   = 5'(off_s) + 5'(size_s);
        split_s = (sum_s > 5'(B));
        mask_s  = '0;
        for (int i = 0; i < 2 * B; i++) begin
            mask_s[i] = (i < int'(size_s));
        end
        // low half of the shifted pair serves ACC1, high half serves ACC2
        lanes_s      = mask_s << off_s;
        wide_wdata_s = {{DATA_W{1'b0}}, req_data2_s} << {off_s, 3'b000};
        base_addr_s  = {req_addr_s[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        next_addr_s  = base_addr_s + ADDR_W'(B);
        legal_s      = f3_legal(req_store_s, req_func3_s);
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (MEM_READ || MEM_WRITE) begin
                    if (!legal_s) begin
                        state_next = DONE;
`ifdef MISALIGN_TRAP_EN
                    end else if (split_s) begin
                        state_next = DONE;
`endif
                    end else begin
                        state_next = ACC1;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            ACC1: begin
                if (mem_busywait) begin
                    state_next = ACC1;
                end else if (split_s) begin
                    state_next = ACC2;
                end else begin
                    state_next = DONE;
                end
            end
            ACC2: begin
                if (mem_busywait) begin
                    state_next = ACC2;
                end else begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: stall now, and the memory request for the coming state.
    always_comb begin
        busywait_s   = 1'b0;
        mem_read_n   = 1'b0;
        mem_write_n  = 1'b0;
        mem_addr_n   = '0;
        mem_wdata_n  = '0;
        mem_byteen_n = '0;
        case (state_r)
            IDLE:       busywait_s = MEM_READ | MEM_WRITE;
            ACC1, ACC2: busywait_s = 1'b1;
            DONE:       busywait_s = 1'b0;
            default:    busywait_s = 1'b0;
        endcase
        case (state_next)
            ACC1: begin
                mem_read_n   = ~req_store_s;
                mem_write_n  = req_store_s;
                mem_addr_n   = base_addr_s;
                mem_byteen_n = lanes_s[B-1:0];
                mem_wdata_n  = wide_wdata_s[DATA_W-1:0];
            end
            ACC2: begin
                mem_read_n   = ~req_store_s;
                mem_write_n  = req_store_s;
                mem_addr_n   = next_addr_s;
                mem_byteen_n = lanes_s[2*B-1:B];
                mem_wdata_n  = wide_wdata_s[2*DATA_W-1:DATA_W];
            end
            default: begin
                mem_read_n = 1'b0;
            end
        endcase
    end

    assign BUSYWAIT = busywait_s;

    // Memory-side request registers; reset drops the strobes immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_byteen <= '0;
        end else begin
            mem_read   <= mem_read_n;
            mem_write  <= mem_write_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_byteen <= mem_byteen_n;
        end
    end

    // Request latch, first-word hold and load result register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            store_r  <= 1'b0;
            func3_r  <= 3'b000;
            addr_r   <= '0;
            data2_r  <= '0;
            hold_r   <= '0;
            DATA_OUT <= '0;
        end else begin
            if ((state_r == IDLE) && (MEM_READ || MEM_WRITE)) begin
                store_r <= MEM_WRITE;
                func3_r <= FUNC3;
                addr_r  <= ADDR;
                data2_r <= DATA2;
            end
            if ((state_r == ACC1) && !mem_busywait) begin
                hold_r <= mem_rdata;
            end
            // IDLE straight to DONE means no access was made: result is zero
            if ((state_r == IDLE) && (state_next == DONE)) begin
                DATA_OUT <= '0;
            end else if ((state_next == DONE) && !req_store_s && (state_r == ACC2)) begin
                DATA_OUT <= refine({mem_rdata, hold_r}, off_s, req_func3_s);
            end else if ((state_next == DONE) && !req_store_s && (state_r == ACC1)) begin
                DATA_OUT <= refine({{DATA_W{1'b0}}, mem_rdata}, off_s, req_func3_s);
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_r;

    // Flag is high only for the DONE cycle that follows a trapped request.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= (state_r == IDLE) && (MEM_READ || MEM_WRITE) && legal_s && split_s;
        end
    end

    assign MISALIGN = misalign_r;
`endif

endmodule

// File: tb/tb_ls_align_unit.sv
`timescale 1ns/1ps
module tb_ls_align_unit;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic [2:0]    FUNC3;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] DATA2;
    logic [DW-1:0] DATA_OUT;
    logic          BUSYWAIT;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_byteen;
    logic [DW-1:0] mem_rdata;
    logic          mem_busywait;

    ls_align_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNC3(FUNC3), .ADDR(ADDR), .DATA2(DATA2), .DATA_OUT(DATA_OUT),
        .BUSYWAIT(BUSYWAIT), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
        .mem_rdata(mem_rdata), .mem_busywait(mem_busywait)
    );

    always #5 CLK = ~CLK;

    // memory image: 64 words, read-only from the memory side
    logic [31:0] mem [0:63];
    assign mem_rdata = mem[mem_addr[7:2]];

    // memory stall: each strobe is held off for stall_cfg cycles
    int         stall_cfg;
    logic [7:0] busy_cnt = 8'd0;
    assign mem_busywait = (mem_read || mem_write) && (int'(busy_cnt) < stall_cfg);

    always @(posedge CLK) begin
        busy_cnt <= ((mem_read || mem_write) && mem_busywait) ? busy_cnt + 8'd1 : 8'd0;
    end

    // accepted-transaction log
    int          n_acc = 0;
    logic        log_rd   [0:1023];
    logic [31:0] log_addr [0:1023];
    logic [31:0] log_wd   [0:1023];
    logic [3:0]  log_be   [0:1023];

    always @(posedge CLK) begin
        if ((mem_read || mem_write) && !mem_busywait) begin
            log_rd[n_acc % 1024]   <= mem_read;
            log_addr[n_acc % 1024] <= mem_addr;
            log_wd[n_acc % 1024]   <= mem_wdata;
            log_be[n_acc % 1024]   <= mem_byteen;
            n_acc <= n_acc + 1;
        end
    end

    // protocol monitor: exclusive strobes, stable request while stalled
    int          both_hi = 0;
    int          unstable = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] p_addr, p_wd;
    logic [3:0]  p_be;
    logic        p_rd, p_wr;

    always @(negedge CLK) begin
        if (RESET) begin
            prev_busy <= 1'b0;
        end else begin
            if (mem_read && mem_write) both_hi <= both_hi + 1;
            if (prev_busy && (mem_addr !== p_addr || mem_read !== p_rd || mem_write !== p_wr ||
                              mem_byteen !== p_be || mem_wdata !== p_wd))
                unstable <= unstable + 1;
            prev_busy <= (mem_read || mem_write) && mem_busywait;
            p_addr <= mem_addr;
            p_wd   <= mem_wdata;
            p_be   <= mem_byteen;
            p_rd   <= mem_read;
            p_wr   <= mem_write;
        end
    end

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_dout;
    int          last_base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return w[8*int'(a[1:0]) +: 8];
    endfunction

    // Issue one request, wait for completion and compare with a byte-level model.
    task automatic run_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] d2,
                           input int stall, input string tag);
        logic            st, legal, split;
        int              size, off, busy, exp_busy, exp_nacc, base, j, idx;
        logic [31:0]     e_addr [2];
        logic [3:0]      e_be   [2];
        logic [31:0]     e_wd   [2];
        logic [31:0]     ba, m;
        longint unsigned v;

        st    = wr;
        size  = 1 << f3[1:0];
        off   = int'(addr[1:0]);
        legal = st ? (f3 <= 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        split = (off + size) > 4;
        for (int i = 0; i < 2; i++) begin
            e_addr[i] = 32'd0; e_be[i] = 4'd0; e_wd[i] = 32'd0;
        end
        v = 64'd0;
        if (legal) begin
            for (int k = 0; k < size; k++) begin
                ba = addr + 32'(k);
                j  = (off + k) / 4;
                e_addr[j] = {ba[31:2], 2'b00};
                e_be[j][ba[1:0]] = 1'b1;
                e_wd[j][8*int'(ba[1:0]) +: 8] = d2[8*k +: 8];
                v = v | (longint'(byte_at(ba)) << (8*k));
            end
            if (!f3[2] && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
        end
        exp_busy = !legal ? 1 : (split ? 3 + 2*stall : 2 + stall);
        exp_nacc = !legal ? 0 : (split ? 2 : 1);
        if (!legal) exp_dout = 32'd0;
        else if (!st) exp_dout = v[31:0];

        base = n_acc;
        last_base = base;
        stall_cfg = stall;
        MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; ADDR = addr; DATA2 = d2;
        #1;
        busy = 0;
        while (BUSYWAIT === 1'b1 && busy < 60) begin
            busy++;
            @(negedge CLK);
        end
        check({tag, "/busy_cycles"}, 64'(busy), 64'(exp_busy));
        check({tag, "/strobes_done"}, {62'd0, mem_read, mem_write}, 64'd0);
        check({tag, "/n_access"}, 64'(n_acc - base), 64'(exp_nacc));
        for (int i = 0; i < exp_nacc; i++) begin
            idx = (base + i) % 1024;
            check({tag, "/is_read"}, {63'd0, log_rd[idx]}, {63'd0, ~st});
            check({tag, "/addr"}, {32'd0, log_addr[idx]}, {32'd0, e_addr[i]});
            check({tag, "/byteen"}, {60'd0, log_be[idx]}, {60'd0, e_be[i]});
            if (st) begin
                m = {{8{e_be[i][3]}}, {8{e_be[i][2]}}, {8{e_be[i][1]}}, {8{e_be[i][0]}}};
                check({tag, "/wdata"}, {32'd0, log_wd[idx] & m}, {32'd0, e_wd[i]});
            end
        end
        check({tag, "/data_out"}, {32'd0, DATA_OUT}, {32'd0, exp_dout});
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int          wait_cnt;
        int          op;
        logic [2:0]  rf3;
        RESET = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b0; FUNC3 = 3'd0;
        ADDR = 32'd0; DATA2 = 32'd0; stall_cfg = 0; exp_dout = 32'd0; last_base = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        repeat (2) @(negedge CLK);
        check("reset/data_out", {32'd0, DATA_OUT}, 64'd0);
        check("reset/busywait", {63'd0, BUSYWAIT}, 64'd0);
        check("reset/strobes", {62'd0, mem_read, mem_write}, 64'd0);
        check("reset/mem_addr", {32'd0, mem_addr}, 64'd0);
        check("reset/byteen_wdata", {28'd0, mem_byteen, mem_wdata}, 64'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // signed byte load from the top lane
        mem[0] = 32'h8011_2233;
        run_req(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 0, "lb_103");
        check("lb_103/addr_const", {32'd0, log_addr[last_base % 1024]}, 64'h100);
        check("lb_103/be_const", {60'd0, log_be[last_base % 1024]}, 64'b1000);
        check("lb_103/dout_const", {32'd0, DATA_OUT}, 64'hFFFF_FF80);

        // halfword store in the upper half
        run_req(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 0, "sh_202");
        check("sh_202/be_const", {60'd0, log_be[last_base % 1024]}, 64'b1100);
        check("sh_202/wd_const", {32'd0, log_wd[last_base % 1024]}, 64'hBEEF_0000);

        // word load crossing a word boundary
        mem[63] = 32'h1234_5678;
        mem[0]  = 32'h9ABC_DEF0;
        run_req(1'b1, 1'b0, 3'b010, 32'h0000_00FE, 32'd0, 0, "lw_0fe");
        check("lw_0fe/addr1", {32'd0, log_addr[last_base % 1024]}, 64'h0FC);
        check("lw_0fe/addr2", {32'd0, log_addr[(last_base + 1) % 1024]}, 64'h100);
        check("lw_0fe/dout_const", {32'd0, DATA_OUT}, 64'hDEF0_1234);

        // word store crossing a word boundary
        run_req(1'b0, 1'b1, 3'b010, 32'h0000_00FF, 32'h1122_3344, 0, "sw_0ff");
        check("sw_0ff/be1", {60'd0, log_be[last_base % 1024]}, 64'b1000);
        check("sw_0ff/wd1", {32'd0, log_wd[last_base % 1024]}, 64'h4400_0000);
        check("sw_0ff/be2", {60'd0, log_be[(last_base + 1) % 1024]}, 64'b0111);
        check("sw_0ff/wd2", {32'd0, log_wd[(last_base + 1) % 1024]}, 64'h0011_2233);

        // long memory stall on an aligned access, then on a split one
        run_req(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 5, "lw_stall5");
        run_req(1'b1, 1'b0, 3'b101, 32'h0000_0023, 32'd0, 2, "lhu_split_stall");

        // illegal encodings: no access, zero result
        run_req(1'b1, 1'b0, 3'b111, 32'h0000_0040, 32'd0, 0, "illegal_load");
        check("illegal_load/dout_const", {32'd0, DATA_OUT}, 64'd0);
        run_req(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'd0, 0, "lw_after_illegal");
        run_req(1'b0, 1'b1, 3'b100, 32'h0000_0048, 32'h1234_5678, 0, "illegal_store");

        // both strobes high: store wins
        run_req(1'b1, 1'b1, 3'b000, 32'h0000_0031, 32'h0000_00A5, 1, "both_store_wins");

        // second access address wraps around the address space
        run_req(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, 0, "lw_wrap");
        check("lw_wrap/addr2", {32'd0, log_addr[(last_base + 1) % 1024]}, 64'h0);

        // reset while the second half of a split store is stalled
        stall_cfg = 6;
        MEM_WRITE = 1'b1; FUNC3 = 3'b010; ADDR = 32'h0000_00FF; DATA2 = 32'h5566_7788;
        wait_cnt = 0;
        while (!(mem_write === 1'b1 && mem_addr === 32'h100) && wait_cnt < 100) begin
            @(negedge CLK);
            wait_cnt++;
        end
        check("rst_acc2/reached", {63'd0, wait_cnt < 100}, 64'd1);
        RESET = 1'b1;
        #1;
        exp_dout = 32'd0;
        check("rst_acc2/mem_write", {63'd0, mem_write}, 64'd0);
        check("rst_acc2/mem_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_acc2/data_out", {32'd0, DATA_OUT}, 64'd0);
        MEM_WRITE = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        mem[0] = 32'h0000_00FF;
        run_req(1'b1, 1'b0, 3'b100, 32'h0000_0000, 32'd0, 0, "lbu_after_rst");
        check("lbu_after_rst/dout_const", {32'd0, DATA_OUT}, 64'h0000_00FF);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            op  = $urandom_range(0, 9);
            rf3 = 3'($urandom_range(0, 7));
            if (op < 5)
                run_req(1'b1, 1'b0, rf3, $urandom, 32'd0, $urandom_range(0, 2), "rnd_load");
            else if (op < 9)
                run_req(1'b0, 1'b1, rf3, $urandom, $urandom, $urandom_range(0, 2), "rnd_store");
            else
                run_req(1'b1, 1'b1, rf3, $urandom, $urandom, $urandom_range(0, 2), "rnd_both");
        end

        check("monitor/both_strobes", 64'(both_hi), 64'd0);
        check("monitor/unstable_stall", 64'(unstable), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
